// File: rtl/bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan
//   Time-multiplexed driver for a 3-digit seven-segment display that shows a
//   two-digit BCD count and a direction glyph ('U' up, 'd' down).
//   Each digit slot lasts REFRESH_DIV clocks. The first BLANK_CYC clocks of
//   every slot turn all anodes off, which suppresses ghosting. The inputs are
//   captured once per frame (slot 0, count 0), so a frame never shows a mix
//   of old and new digits.
//
// Parameters
//   REFRESH_DIV : clocks per digit slot (>= 2)
//   BLANK_CYC   : all-anodes-off clocks at the start of each slot
//                 (1 <= BLANK_CYC < REFRESH_DIV)
//
// Ports
//   clk   in  1  system clock, rising edge
//   rst   in  1  asynchronous active-high reset
//   units in  4  BCD units digit
//   tens  in  4  BCD tens digit
//   dir   in  1  count direction, 1 = up, 0 = down
//   seg   out 7  cathodes {g,f,e,d,c,b,a}, active-low
//   dp    out 1  decimal point, active-low, held off
//   an    out 8  anodes, active-low, an[0] = rightmost digit
//   frame out 1  one-clock pulse after each input snapshot
//
// Configuration macro
//   BCD_SEG_LZB_EN : when defined, a tens digit of 0 is blanked (an[1]
//                    stays high through its slot).
// ---------------------------------------------------------------------------
module bcd_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic       dir,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic       frame
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    // BCD to active-low segment pattern; non-decimal codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Direction glyph: 'U' for up, 'd' for down.
    function automatic logic [6:0] dir_to_seg(input logic d);
        logic [6:0] s;
        if (d) begin
            s = 7'b1000001;
        end else begin
            s = 7'b0100001;
        end
        return s;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       units_q, units_d;
    logic [3:0]       tens_q, tens_d;
    logic             dir_q, dir_d;
    logic [6:0]       seg_q, seg_d;
    logic [7:0]       an_q, an_d;
    logic             frame_q, frame_d;
    logic             dp_q, dp_d;

    logic             wrap_s;
    logic             snap_s;
    logic             lzb_s;
    state_e           state_s;

    // Slot timing, snapshot capture and next-output computation.
    always_comb begin
        wrap_s  = (cnt_q == CNT_MAX);
        snap_s  = (cnt_q == {CNT_W{1'b0}}) && (idx_q == 2'd0);
        state_s = (cnt_q < BLANK_END) ? ST_BLANK : ST_SHOW;

`ifdef BCD_SEG_LZB_EN
        lzb_s = (tens_q == 4'd0);
`else
        lzb_s = 1'b0;
`endif

        if (wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
            case (idx_q)
                2'd0:    idx_d = 2'd1;
                2'd1:    idx_d = 2'd2;
                default: idx_d = 2'd0;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end

        if (snap_s) begin
            units_d = units;
            tens_d  = tens;
            dir_d   = dir;
        end else begin
            units_d = units_q;
            tens_d  = tens_q;
            dir_d   = dir_q;
        end

        an_d  = 8'hFF;
        seg_d = 7'h7F;
        if (state_s == ST_SHOW) begin
            case (idx_q)
                2'd0: begin
                    an_d[0] = 1'b0;
                    seg_d   = bcd_to_seg(units_q);
                end
                2'd1: begin
                    if (lzb_s) begin
                        an_d  = 8'hFF;
                        seg_d = 7'h7F;
                    end else begin
                        an_d[1] = 1'b0;
                        seg_d   = bcd_to_seg(tens_q);
                    end
                end
                2'd2: begin
                    an_d[2] = 1'b0;
                    seg_d   = dir_to_seg(dir_q);
                end
                default: begin
                    an_d  = 8'hFF;
                    seg_d = 7'h7F;
                end
            endcase
        end else begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
        end

        frame_d = snap_s;
        dp_d    = 1'b1;
    end

    // State and registered outputs; reset forces the dark display at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= 2'd0;
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            dir_q   <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= 8'hFF;
            frame_q <= 1'b0;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            dir_q   <= dir_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            dp_q    <= dp_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg_scan
//   Directed bench for bcd_seg_scan with REFRESH_DIV = 8, BLANK_CYC = 2.
//   Each table record gives the inputs for one frame and the hand-decoded
//   segment patterns of its three digits. A frame is 24 clocks; after edge
//   number s (s = 0..23) of a frame the outputs reflect slot idx = s/8 at
//   count c = s%8. Inputs are changed to the next record's values in the
//   middle of every frame, so a design that reads the inputs live instead of
//   the snapshot shows up as a miscompare.
// ---------------------------------------------------------------------------
module tb_bcd_seg_scan;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME_LEN = 3 * RD;

    logic       clk;
    logic       rst;
    logic [3:0] units;
    logic [3:0] tens;
    logic       dir;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       frame;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0] u;
        logic [3:0] t;
        logic       d;
        logic [6:0] seg_u;
        logic [6:0] seg_t;
        logic [6:0] seg_g;
    } vec_t;

    vec_t vecs[7];

    bcd_seg_scan #(
        .REFRESH_DIV(RD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .units(units),
        .tens (tens),
        .dir  (dir),
        .seg  (seg),
        .dp   (dp),
        .an   (an),
        .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_dark(input string name);
        chk8({name, "_an"}, an, 8'hFF);
        chk8({name, "_seg"}, {1'b0, seg}, 8'h7F);
        chk8({name, "_dp"}, {7'd0, dp}, 8'h01);
        chk8({name, "_frame"}, {7'd0, frame}, 8'h00);
    endtask

    // Runs n_steps clocks of a frame showing v; at step 9 the inputs move to nxt.
    task automatic run_frame(input vec_t v, input vec_t nxt, input int n_steps);
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       blank_t;
`ifdef BCD_SEG_LZB_EN
        blank_t = (v.t == 4'd0);
`else
        blank_t = 1'b0;
`endif
        for (int s = 0; s < n_steps; s++) begin
            int ix;
            int c;
            @(posedge clk);
            #1;
            ix = s / RD;
            c  = s % RD;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            if (c >= BC) begin
                if (ix == 0) begin
                    exp_an  = 8'hFE;
                    exp_seg = v.seg_u;
                end else if (ix == 1) begin
                    if (!blank_t) begin
                        exp_an  = 8'hFD;
                        exp_seg = v.seg_t;
                    end
                end else begin
                    exp_an  = 8'hFB;
                    exp_seg = v.seg_g;
                end
            end
            chk8($sformatf("an_s%0d", s), an, exp_an);
            chk8($sformatf("seg_s%0d", s), {1'b0, seg}, {1'b0, exp_seg});
            chk8($sformatf("frame_s%0d", s), {7'd0, frame}, (s == 0) ? 8'h01 : 8'h00);
            chk8($sformatf("dp_s%0d", s), {7'd0, dp}, 8'h01);
            if (s == 9) begin
                units = nxt.u;
                tens  = nxt.t;
                dir   = nxt.d;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //           u      t      d     seg_u        seg_t        seg_g
        vecs[0] = '{4'd4, 4'd2, 1'b1, 7'b0011001, 7'b0100100, 7'b1000001};
        vecs[1] = '{4'd7, 4'd2, 1'b1, 7'b1111000, 7'b0100100, 7'b1000001};
        vecs[2] = '{4'hC, 4'd5, 1'b0, 7'b0111111, 7'b0010010, 7'b0100001};
        vecs[3] = '{4'd9, 4'd0, 1'b0, 7'b0010000, 7'b1000000, 7'b0100001};
        vecs[4] = '{4'd0, 4'hA, 1'b1, 7'b1000000, 7'b0111111, 7'b1000001};
        vecs[5] = '{4'd8, 4'd6, 1'b0, 7'b0000000, 7'b0000010, 7'b0100001};
        vecs[6] = '{4'd1, 4'd3, 1'b1, 7'b1111001, 7'b0110000, 7'b1000001};

        // Reset state, visible without any clock edge.
        rst   = 1'b1;
        units = vecs[0].u;
        tens  = vecs[0].t;
        dir   = vecs[0].d;
        #1;
        chk_outputs_dark("reset0");
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_dark("reset_hold");

        // Release between edges; the next edge is frame step 0.
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], vecs[(i + 1) % 7], FRAME_LEN);
        end

        // Reset in the middle of the tens SHOW window.
        run_frame(vecs[0], vecs[2], 13);
        chk8("pre_rst_an", an, 8'hFD);
        #3;
        rst = 1'b1;
        #1;
        chk_outputs_dark("async_rst");
        @(posedge clk);
        #1;
        chk_outputs_dark("rst_held");
        @(negedge clk);
        rst = 1'b0;
        // Inputs now hold vecs[2]; a fresh frame must show them from idx0.
        run_frame(vecs[2], vecs[3], FRAME_LEN);
        run_frame(vecs[3], vecs[3], FRAME_LEN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
